// File: rtl/id_ex_stage_if.sv
// Bundle between the ID/EX pipeline register and the rest of the core.
// The master modport drives the decode, forwarding and control inputs. The slave modport is the stage itself.
interface id_ex_stage_if #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4
);
    logic               stall_i;
    logic               flush_i;
    logic               id_valid_i;
    logic [XLEN-1:0]    id_pc_i;
    logic [REG_AW-1:0]  id_rs1_addr_i;
    logic [REG_AW-1:0]  id_rs2_addr_i;
    logic [REG_AW-1:0]  id_rd_addr_i;
    logic [XLEN-1:0]    id_rs1_data_i;
    logic [XLEN-1:0]    id_rs2_data_i;
    logic [XLEN-1:0]    id_imm_i;
    logic [ALUOP_W-1:0] id_alu_op_i;
    logic               id_opa_sel_i;
    logic               id_opb_sel_i;
    logic               id_rd_wren_i;
    logic               id_mem_rden_i;
    logic               id_uses_rs1_i;
    logic               id_uses_rs2_i;
    logic [REG_AW-1:0]  mem_rd_addr_i;
    logic               mem_rd_wren_i;
    logic [XLEN-1:0]    mem_fwd_data_i;
    logic [REG_AW-1:0]  wb_rd_addr_i;
    logic               wb_rd_wren_i;
    logic [XLEN-1:0]    wb_data_i;
    logic [XLEN-1:0]    operand_a_o;
    logic [XLEN-1:0]    operand_b_o;
    logic [ALUOP_W-1:0] alu_op_o;
    logic               ex_valid_o;
    logic [XLEN-1:0]    ex_pc_o;
    logic [REG_AW-1:0]  ex_rd_addr_o;
    logic               ex_rd_wren_o;
    logic               ex_mem_rden_o;
    logic [XLEN-1:0]    ex_store_data_o;
    logic               load_use_stall_o;

    modport master (
        output stall_i, flush_i, id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i,
               id_rd_addr_i, id_rs1_data_i, id_rs2_data_i, id_imm_i, id_alu_op_i,
               id_opa_sel_i, id_opb_sel_i, id_rd_wren_i, id_mem_rden_i,
               id_uses_rs1_i, id_uses_rs2_i, mem_rd_addr_i, mem_rd_wren_i,
               mem_fwd_data_i, wb_rd_addr_i, wb_rd_wren_i, wb_data_i,
        input  operand_a_o, operand_b_o, alu_op_o, ex_valid_o, ex_pc_o, ex_rd_addr_o,
               ex_rd_wren_o, ex_mem_rden_o, ex_store_data_o, load_use_stall_o
    );

    modport slave (
        input  stall_i, flush_i, id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i,
               id_rd_addr_i, id_rs1_data_i, id_rs2_data_i, id_imm_i, id_alu_op_i,
               id_opa_sel_i, id_opb_sel_i, id_rd_wren_i, id_mem_rden_i,
               id_uses_rs1_i, id_uses_rs2_i, mem_rd_addr_i, mem_rd_wren_i,
               mem_fwd_data_i, wb_rd_addr_i, wb_rd_wren_i, wb_data_i,
        output operand_a_o, operand_b_o, alu_op_o, ex_valid_o, ex_pc_o, ex_rd_addr_o,
               ex_rd_wren_o, ex_mem_rden_o, ex_store_data_o, load_use_stall_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use bubble insertion.
// Forwarding works from the registered source indices, so it adds no latency in front of the ALU.
module id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4
) (
    input logic          clk_i,
    input logic          rst_ni,
    id_ex_stage_if.slave bus
);
    logic               ex_valid;
    logic [XLEN-1:0]    ex_pc;
    logic [REG_AW-1:0]  ex_rs1_addr;
    logic [REG_AW-1:0]  ex_rs2_addr;
    logic [REG_AW-1:0]  ex_rd_addr;
    logic [XLEN-1:0]    ex_rs1_data;
    logic [XLEN-1:0]    ex_rs2_data;
    logic [XLEN-1:0]    ex_imm;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic               ex_opa_sel;
    logic               ex_opb_sel;
    logic               ex_rd_wren;
    logic               ex_mem_rden;
    logic               load_use;
    logic [XLEN-1:0]    fwd_rs1;
    logic [XLEN-1:0]    fwd_rs2;

    // A flushed ID instruction never reaches EX, so it cannot cause a hazard.
    always_comb begin
        load_use = ex_valid && ex_mem_rden && (ex_rd_addr != '0) && bus.id_valid_i &&
                   ((bus.id_uses_rs1_i && (bus.id_rs1_addr_i == ex_rd_addr)) ||
                    (bus.id_uses_rs2_i && (bus.id_rs2_addr_i == ex_rd_addr))) &&
                   !bus.flush_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_rd_addr  <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_alu_op   <= '0;
            ex_opa_sel  <= 1'b0;
            ex_opb_sel  <= 1'b0;
            ex_rd_wren  <= 1'b0;
            ex_mem_rden <= 1'b0;
        end else if (bus.stall_i) begin
            ex_valid    <= ex_valid;
        end else if (bus.flush_i || load_use) begin
            ex_valid    <= 1'b0;
            ex_alu_op   <= '0;
            ex_rd_wren  <= 1'b0;
            ex_mem_rden <= 1'b0;
        end else begin
            ex_valid    <= bus.id_valid_i;
            ex_pc       <= bus.id_pc_i;
            ex_rs1_addr <= bus.id_rs1_addr_i;
            ex_rs2_addr <= bus.id_rs2_addr_i;
            ex_rd_addr  <= bus.id_rd_addr_i;
            ex_rs1_data <= bus.id_rs1_data_i;
            ex_rs2_data <= bus.id_rs2_data_i;
            ex_imm      <= bus.id_imm_i;
            ex_alu_op   <= bus.id_alu_op_i;
            ex_opa_sel  <= bus.id_opa_sel_i;
            ex_opb_sel  <= bus.id_opb_sel_i;
            ex_rd_wren  <= bus.id_rd_wren_i && bus.id_valid_i;
            ex_mem_rden <= bus.id_mem_rden_i && bus.id_valid_i;
        end
    end

    // MEM is checked before WB so the youngest producer wins; x0 is never forwarded.
    always_comb begin
        fwd_rs1 = ex_rs1_data;
        fwd_rs2 = ex_rs2_data;
        if (ex_rs1_addr != '0) begin
            if (bus.mem_rd_wren_i && (bus.mem_rd_addr_i == ex_rs1_addr))
                fwd_rs1 = bus.mem_fwd_data_i;
            else if (bus.wb_rd_wren_i && (bus.wb_rd_addr_i == ex_rs1_addr))
                fwd_rs1 = bus.wb_data_i;
        end
        if (ex_rs2_addr != '0) begin
            if (bus.mem_rd_wren_i && (bus.mem_rd_addr_i == ex_rs2_addr))
                fwd_rs2 = bus.mem_fwd_data_i;
            else if (bus.wb_rd_wren_i && (bus.wb_rd_addr_i == ex_rs2_addr))
                fwd_rs2 = bus.wb_data_i;
        end
    end

    assign bus.operand_a_o      = ex_opa_sel ? ex_pc : fwd_rs1;
    assign bus.operand_b_o      = ex_opb_sel ? ex_imm : fwd_rs2;
    assign bus.ex_store_data_o  = fwd_rs2;
    assign bus.alu_op_o         = ex_alu_op;
    assign bus.ex_valid_o       = ex_valid;
    assign bus.ex_pc_o          = ex_pc;
    assign bus.ex_rd_addr_o     = ex_rd_addr;
    assign bus.ex_rd_wren_o     = ex_rd_wren;
    assign bus.ex_mem_rden_o    = ex_mem_rden;
    assign bus.load_use_stall_o = load_use;
endmodule
